// File: rtl/fifo_pop_arbiter_if.sv
// Signal bundle between the VC-drain arbiter and the source/destination FIFOs.
// master = arbiter side, slave = FIFO/environment side.
interface fifo_pop_arbiter_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
);
  // Strobe semantics: vcX_pop asks the source FIFO for one word; the FIFO acts on
  // it at the rising edge where it is seen high and returns the word on vcX_data
  // in the following cycle. dX_push is a one-cycle write strobe qualifying
  // data_out. Neither strobe has a ready: empty/almost_full gate new pops only.
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  d0_count;
  logic [CNT_WIDTH-1:0]  d1_count;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out, busy, d0_count, d1_count
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, busy, d0_count, d1_count
  );
endinterface

// File: rtl/fifo_pop_arbiter.sv
// Drains two VC source FIFOs round-robin, one word in flight at a time, and
// routes each word to destination D0/D1 by its header bit.
module fifo_pop_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int DEST_BIT   = 11,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  fifo_pop_arbiter_if.master      bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state;
  logic                  last;
  logic                  sel;
  logic                  elig0;
  logic                  elig1;
  logic                  grant_any;
  logic                  grant_vc;
  logic [DATA_WIDTH-1:0] word;

  // Destination is unknown until the word is read, so both must have room.
  always_comb begin
    elig0     = ~bus.vc0_empty & ~bus.d0_almost_full & ~bus.d1_almost_full;
    elig1     = ~bus.vc1_empty & ~bus.d0_almost_full & ~bus.d1_almost_full;
    grant_any = elig0 | elig1;
    grant_vc  = (elig0 & elig1) ? ~last : elig1;
  end

  assign word      = sel ? bus.vc1_data : bus.vc0_data;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      sel          <= 1'b0;
      bus.vc0_pop  <= 1'b0;
      bus.vc1_pop  <= 1'b0;
      bus.d0_push  <= 1'b0;
      bus.d1_push  <= 1'b0;
      bus.data_out <= '0;
      bus.busy     <= 1'b0;
      bus.d0_count <= '0;
      bus.d1_count <= '0;
    end else begin
      bus.vc0_pop <= 1'b0;
      bus.vc1_pop <= 1'b0;
      bus.d0_push <= 1'b0;
      bus.d1_push <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state       <= POP;
            sel         <= grant_vc;
            last        <= grant_vc;
            bus.vc0_pop <= ~grant_vc;
            bus.vc1_pop <= grant_vc;
            bus.busy    <= 1'b1;
          end
        end
        POP: begin
          state <= WAIT;
        end
        WAIT: begin
          // Source FIFO drives the popped word this cycle; capture and route it.
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.data_out <= word;
          bus.d0_push  <= ~word[DEST_BIT];
          bus.d1_push  <= word[DEST_BIT];
          if (word[DEST_BIT]) bus.d1_count <= bus.d1_count + 1'b1;
          else                bus.d0_count <= bus.d0_count + 1'b1;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Read-side controller for the transaction-layer FIFOs. It drains two virtual-channel source FIFOs (VC0, VC1) by issuing `pop` pulses, captures the 12-bit word each FIFO returns, and pushes it into one of two destination FIFOs selected by a header bit. It sits between the VC FIFOs and the per-destination FIFOs. It honours destination `almost_full` backpressure and keeps per-destination word counts for the bench and status logic.

## Interface
- `DATA_WIDTH`, 12, word width; matches the FIFO data width.
- `DEST_BIT`, 11, index of the word bit that selects the destination (0 → D0, 1 → D1).
- `CNT_WIDTH`, 8, width of each per-destination push counter.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high. Asserting it clears all state immediately; release is sampled on `clk`.
- `vc0_empty` in 1: VC0 FIFO holds no words.
- `vc1_empty` in 1: VC1 FIFO holds no words.
- `vc0_data` in DATA_WIDTH: VC0 FIFO read data.
- `vc1_data` in DATA_WIDTH: VC1 FIFO read data.
- `d0_almost_full` in 1: D0 FIFO almost_full flag.
- `d1_almost_full` in 1: D1 FIFO almost_full flag.
- `vc0_pop` out 1: registered pop strobe to VC0, one cycle wide.
- `vc1_pop` out 1: registered pop strobe to VC1, one cycle wide.
- `d0_push` out 1: registered push strobe to D0, one cycle wide.
- `d1_push` out 1: registered push strobe to D1, one cycle wide.
- `data_out` out DATA_WIDTH: word presented with `d0_push`/`d1_push`; holds its last value otherwise.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `d0_count` out CNT_WIDTH: number of D0 pushes, modulo 2^CNT_WIDTH.
- `d1_count` out CNT_WIDTH: number of D1 pushes, modulo 2^CNT_WIDTH.

## Operation
- FSM states: IDLE, POP, WAIT.
- **Eligibility.** Evaluated only in IDLE. VCx is eligible when `vcx_empty`=0, `d0_almost_full`=0 and `d1_almost_full`=0. Both destinations are checked because the destination is unknown until the word is read.
- **Grant.** Round-robin using a 1-bit `last` register (reset value 1, so VC0 wins the first tie).
  - If only one VC is eligible, it is granted.
  - If both are eligible, the VC not equal to `last` is granted.
  - `last` updates to the granted VC.
- **IDLE → POP** on any grant; the matching `vcx_pop` is 1 during POP. IDLE stays IDLE with no grant.
- **POP → WAIT** unconditionally. The source FIFO samples `pop` at this edge and drives the word during WAIT.
- **WAIT → IDLE** unconditionally. At this edge:
  - `data_out` ← granted `vcx_data`.
  - `d0_push` ← ~word[DEST_BIT]; `d1_push` ← word[DEST_BIT].
  - The matching count increments; 8-bit counts wrap 255 → 0.
- Push is high during the first IDLE cycle after WAIT. A new grant decided in that same cycle is allowed.
- At most one pop is in flight. The empty flag is re-read only after the previous word has been captured, so a single-entry FIFO is never over-popped.
- Backpressure only blocks new grants. A pop already issued always completes its push, so `almost_full` thresholds must leave at least one free entry.
- **Reset (any time, including mid-transfer):**
  - State → IDLE, `last` → 1.
  - All pop/push → 0, `data_out` → 0, `busy` → 0, counts → 0.
  - An in-flight word is discarded. The source FIFO has already consumed it; this is intended.

## Timing
- Cycle C0 (IDLE, eligible) → C1 `vcx_pop`=1 → C2 source word valid, `busy`=1 → C3 `dx_push`=1 with `data_out`.
- Pop-to-push latency: 2 cycles. Peak throughput: one word per 3 cycles.
- `busy`=1 exactly in POP and WAIT.
- Pop and push strobes are never high for more than one consecutive cycle per transfer.
- At most one of `vc0_pop`/`vc1_pop` is high per cycle; likewise for `d0_push`/`d1_push`.
- Inputs changing during POP/WAIT do not affect the transfer in flight. Only `vcx_data` is sampled, at the WAIT→IDLE edge.

## Test plan
- **Reset:** assert `reset` mid-cycle with no clock edge → all outputs 0 immediately. Release with both VCs empty → no pops for 20 cycles.
- **Single VC0 word 0x123** (bit 11 = 0), destinations not full → `vc0_pop` in C1, `d0_push`=1 with `data_out`=0x123 in C3, `d0_count`=1, `d1_count`=0.
- **Both VCs non-empty continuously:**
  - VC0 words 0x800…, VC1 words 0x001… → pops alternate VC0, VC1, VC0, VC1 with pops 3 cycles apart.
  - 0x8xx words go to D1 and the others to D0.
- **Backpressure:** `d1_almost_full`=1 while VC1 is non-empty → no pop. Deassert it → pop on the next cycle.
  - Raise `d0_almost_full` during WAIT → the in-flight push still occurs and no new pop follows.
- **Reset during WAIT** → no push, counts 0. After release, the next tie is granted to VC0.
- **Counter wrap:** push 256 words to D0 → `d0_count` returns to 0 and `d1_count` is unchanged.
